// File: rtl/ks_nibble_gen.sv
// Keystream nibble generator: a 16-bit Galois LFSR advanced four steps per
// accepted nibble, delivered over valid/ready with seed load and start/stop control.
module ks_nibble_gen #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter logic [15:0] TAPS   = 16'hB400,
  parameter int unsigned WARMUP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        start,
  input  logic        stop,
  input  logic        ks_ready,
  output logic        ks_valid,
  output logic [3:0]  ks,
  output logic        busy,
  output logic [15:0] nib_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt, lfsr_adv;
  logic [15:0] count_nxt;
  logic [7:0]  warm_cnt, warm_nxt;
  logic        stop_pend, pend_nxt;
  logic [3:0]  ks_raw;
  logic        hs;

  // Four unrolled Galois steps; bit i of the nibble is the bit shifted out at step i.
  function automatic logic [19:0] step4(input logic [15:0] s);
    logic [15:0] r;
    logic [3:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i] = r[0];
      r    = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    end
    return {k, r};
  endfunction

  assign {ks_raw, lfsr_adv} = step4(lfsr);

  // Outputs depend only on registers, so ks cannot move while a nibble is stalled.
  assign ks_valid = (state == RUN);
  assign ks       = ks_valid ? ks_raw : 4'd0;
  assign busy     = (state != IDLE);
  assign hs       = ks_valid & ks_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    count_nxt = nib_count;
    warm_nxt  = warm_cnt;
    pend_nxt  = stop_pend;

    if (load) begin
      lfsr_nxt  = (seed == 16'd0) ? SEED : seed;
      count_nxt = 16'd0;
      pend_nxt  = 1'b0;
      warm_nxt  = 8'd0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (WARM_INIT != 8'd0) begin
              state_nxt = WARM;
              warm_nxt  = WARM_INIT;
            end else begin
              state_nxt = RUN;
            end
          end
        end

        WARM: begin
          lfsr_nxt = lfsr_adv;
          warm_nxt = warm_cnt - 8'd1;
          if (stop) begin
            state_nxt = IDLE;
            warm_nxt  = 8'd0;
          end else if (warm_cnt <= 8'd1) begin
            state_nxt = RUN;
          end
        end

        RUN: begin
          if (hs) begin
            lfsr_nxt  = lfsr_adv;
            count_nxt = nib_count + 16'd1;
            if (stop || stop_pend) begin
              state_nxt = IDLE;
              pend_nxt  = 1'b0;
            end
          end else if (stop) begin
            // Stalled nibble must still be consumed before leaving RUN.
            pend_nxt = 1'b1;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      nib_count <= 16'd0;
      warm_cnt  <= 8'd0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      nib_count <= count_nxt;
      warm_cnt  <= warm_nxt;
      stop_pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_ks_nibble_gen.sv
// Self-checking bench for ks_nibble_gen: scoreboard of expected nibbles checked
// at each handshake, plus per-scenario inline checks of control behaviour.
module tb_ks_nibble_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] seed;
  logic        start;
  logic        stop;
  logic        ks_ready;

  logic        ks_valid, busy;
  logic [3:0]  ks;
  logic [15:0] nib_count;

  logic        ks_valid_w, busy_w;
  logic [3:0]  ks_w;
  logic [15:0] nib_count_w;

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  sb_exp;
  bit          sb_on = 1'b0;
  logic [15:0] m;

  always #5 clk = ~clk;

  ks_nibble_gen #(.SEED(16'hACE1), .TAPS(16'hB400), .WARMUP(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .start(start),
    .stop(stop), .ks_ready(ks_ready), .ks_valid(ks_valid), .ks(ks),
    .busy(busy), .nib_count(nib_count)
  );

  ks_nibble_gen #(.SEED(16'hACE1), .TAPS(16'hB400), .WARMUP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .start(start),
    .stop(stop), .ks_ready(ks_ready), .ks_valid(ks_valid_w), .ks(ks_w),
    .busy(busy_w), .nib_count(nib_count_w)
  );

  // Reference: four Galois steps, returns {nibble, next_state}.
  function automatic logic [19:0] model4(input logic [15:0] s);
    logic [15:0] r;
    logic [3:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i] = r[0];
      if (r[0]) r = (r >> 1) ^ 16'hB400;
      else      r = r >> 1;
    end
    return {k, r};
  endfunction

  task automatic push_n(input int n);
    logic [19:0] t;
    for (int i = 0; i < n; i++) begin
      t = model4(m);
      exp_q.push_back(t[19:16]);
      m = t[15:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare ks at every handshake of the WARMUP=0 instance.
  always @(negedge clk) begin
    if (sb_on && ks_valid && ks_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: handshake with ks=%h but no nibble expected", ks);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ks !== sb_exp) begin
          n_err++;
          $display("FAIL sb_ks: got %h expected %h", ks, sb_exp);
        end
      end
    end
  end

  task automatic check_sb_empty(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_sb_left: %0d nibbles never handshaken, expected 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    sb_on    = 1'b0;
    rst_n    = 1'b0;
    load     = 1'b0;
    seed     = 16'd0;
    start    = 1'b0;
    stop     = 1'b0;
    ks_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    m = 16'hACE1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({ks_valid, busy, ks, nib_count} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b busy=%b ks=%h cnt=%h expected all 0",
               ks_valid, busy, ks, nib_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    sb_on    = 1'b1;
    start    = 1'b1;
    ks_ready = 1'b1;
    push_n(2);
    tick();
    start = 1'b0;
    n_vec++;
    if (ks_valid !== 1'b1 || ks !== 4'h1 || nib_count !== 16'd0) begin
      n_err++;
      $display("FAIL basic_first: valid=%b ks=%h cnt=%h expected 1 1 0000", ks_valid, ks, nib_count);
    end
    tick();
    n_vec++;
    if (ks !== 4'hE || nib_count !== 16'd1) begin
      n_err++;
      $display("FAIL basic_second: ks=%h cnt=%h expected e 0001", ks, nib_count);
    end
    tick();
    ks_ready = 1'b0;
    n_vec++;
    if (nib_count !== 16'd2) begin
      n_err++;
      $display("FAIL basic_count2: cnt=%h expected 0002", nib_count);
    end
    tick();
    check_sb_empty("basic");
  endtask

  task automatic test_stall();
    do_reset();
    sb_on    = 1'b1;
    start    = 1'b1;
    ks_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (ks_valid !== 1'b1 || ks !== 4'h1 || nib_count !== 16'd0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid=%b ks=%h cnt=%h expected 1 1 0000",
                 i, ks_valid, ks, nib_count);
      end
      tick();
    end
    ks_ready = 1'b1;
    push_n(2);
    tick();
    n_vec++;
    if (ks !== 4'hE || nib_count !== 16'd1) begin
      n_err++;
      $display("FAIL stall_release: ks=%h cnt=%h expected e 0001", ks, nib_count);
    end
    tick();
    ks_ready = 1'b0;
    n_vec++;
    if (nib_count !== 16'd2) begin
      n_err++;
      $display("FAIL stall_count: cnt=%h expected 0002", nib_count);
    end
    tick();
    check_sb_empty("stall");
  endtask

  task automatic test_stop();
    do_reset();
    sb_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    n_vec++;
    if (ks_valid !== 1'b1 || busy !== 1'b1 || ks !== 4'h1) begin
      n_err++;
      $display("FAIL stop_deferred: valid=%b busy=%b ks=%h expected 1 1 1", ks_valid, busy, ks);
    end
    ks_ready = 1'b1;
    push_n(1);
    tick();
    ks_ready = 1'b0;
    n_vec++;
    if (ks_valid !== 1'b0 || busy !== 1'b0 || nib_count !== 16'd1) begin
      n_err++;
      $display("FAIL stop_idle: valid=%b busy=%b cnt=%h expected 0 0 0001", ks_valid, busy, nib_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (ks_valid !== 1'b1 || ks !== 4'hE) begin
      n_err++;
      $display("FAIL stop_restart: valid=%b ks=%h expected 1 e", ks_valid, ks);
    end
    ks_ready = 1'b1;
    push_n(1);
    tick();
    n_vec++;
    if (busy !== 1'b1 || nib_count !== 16'd2) begin
      n_err++;
      $display("FAIL stop_pend_clear: busy=%b cnt=%h expected 1 0002", busy, nib_count);
    end
    stop = 1'b1;
    push_n(1);
    tick();
    stop     = 1'b0;
    ks_ready = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || ks_valid !== 1'b0 || nib_count !== 16'd3) begin
      n_err++;
      $display("FAIL stop_immediate: busy=%b valid=%b cnt=%h expected 0 0 0003", busy, ks_valid, nib_count);
    end
    check_sb_empty("stop");
  endtask

  task automatic test_load();
    do_reset();
    sb_on    = 1'b1;
    start    = 1'b1;
    ks_ready = 1'b1;
    push_n(2);
    tick();
    start = 1'b0;
    tick();
    load = 1'b1;
    seed = 16'd0;
    tick();
    load     = 1'b0;
    ks_ready = 1'b0;
    m        = 16'hACE1;
    n_vec++;
    if (ks_valid !== 1'b0 || busy !== 1'b0 || nib_count !== 16'd0) begin
      n_err++;
      $display("FAIL load_zero: valid=%b busy=%b cnt=%h expected 0 0 0000", ks_valid, busy, nib_count);
    end
    load  = 1'b1;
    start = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_start_ignored: busy=%b expected 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (ks_valid !== 1'b1 || ks !== 4'h1 || nib_count !== 16'd0) begin
      n_err++;
      $display("FAIL load_restart: valid=%b ks=%h cnt=%h expected 1 1 0000", ks_valid, ks, nib_count);
    end
    load = 1'b1;
    seed = 16'h1234;
    tick();
    load  = 1'b0;
    m     = 16'h1234;
    start = 1'b1;
    tick();
    start    = 1'b0;
    ks_ready = 1'b1;
    push_n(1);
    tick();
    ks_ready = 1'b0;
    n_vec++;
    if (nib_count !== 16'd1) begin
      n_err++;
      $display("FAIL load_seed_count: cnt=%h expected 0001", nib_count);
    end
    tick();
    check_sb_empty("load");
  endtask

  task automatic test_warmup();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy_w !== 1'b1 || ks_valid_w !== 1'b0 || nib_count_w !== 16'd0) begin
      n_err++;
      $display("FAIL warm_phase: busy=%b valid=%b cnt=%h expected 1 0 0000", busy_w, ks_valid_w, nib_count_w);
    end
    tick();
    n_vec++;
    if (ks_valid_w !== 1'b1 || ks_w !== 4'hE || nib_count_w !== 16'd0) begin
      n_err++;
      $display("FAIL warm_first: valid=%b ks=%h cnt=%h expected 1 e 0000", ks_valid_w, ks_w, nib_count_w);
    end
    load = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++;
    if (busy_w !== 1'b0 || ks_valid_w !== 1'b0) begin
      n_err++;
      $display("FAIL warm_abort: busy=%b valid=%b expected 0 0", busy_w, ks_valid_w);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [19:0] t;
    do_reset();
    start = 1'b1;
    tick();
    start    = 1'b0;
    ks_ready = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    n_vec++;
    if (nib_count !== 16'hFFFF || ks_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_full: cnt=%h valid=%b expected ffff 1", nib_count, ks_valid);
    end
    tick();
    n_vec++;
    if (nib_count !== 16'd0) begin
      n_err++;
      $display("FAIL wrap_zero: cnt=%h expected 0000", nib_count);
    end
    m = 16'hACE1;
    for (int i = 0; i < 65536; i++) begin
      t = model4(m);
      m = t[15:0];
    end
    t = model4(m);
    n_vec++;
    if (ks !== t[19:16]) begin
      n_err++;
      $display("FAIL wrap_ks: ks=%h expected %h after 65536 nibbles", ks, t[19:16]);
    end
    ks_ready = 1'b0;
    rst_n    = 1'b0;
    tick();
    n_vec++;
    if ({ks_valid, busy, ks, nib_count} !== 22'd0) begin
      n_err++;
      $display("FAIL midrun_reset: valid=%b busy=%b ks=%h cnt=%h expected all 0",
               ks_valid, busy, ks, nib_count);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stop();
    test_load();
    test_warmup();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
